// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with occupancy count,
// programmable almost-full/almost-empty levels and overflow/underflow pulses.
// Optional macro SYNC_FIFO_FWFT_EN selects first-word-fall-through reads;
// when it is undefined rdata is registered with one cycle of read latency.
// All status flags decode from the registered count, so they only move on
// clock edges. Storage is never reset; reset only clears pointers and count.
module sync_fifo_param #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     wr_en,
  input  logic                     rd_en,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;
  logic          wr_ok, rd_ok;

  // Status flags come straight from the registered occupancy.
  assign count        = count_q;
  assign empty        = (count_q == '0);
  assign full         = (count_q == CW'(DEPTH));
  assign almost_full  = (count_q >= CW'(AF_LEVEL));
  assign almost_empty = (count_q <= CW'(AE_LEVEL));
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // Acceptance and next-state: a write while full only gets in when the
  // head is popped in the same cycle, so count never exceeds DEPTH.
  always_comb begin
    rd_ok       = rd_en && !empty;
    wr_ok       = wr_en && (!full || rd_en);
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = wr_en && !wr_ok;
    underflow_d = rd_en && !rd_ok;
    if (wr_ok) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (rd_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    count_d = count_q + CW'(wr_ok) - CW'(rd_ok);
  end

  // Control state register; reset discards contents by clearing pointers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage write port; requests seen while in reset are dropped.
  always_ff @(posedge clk) begin
    if (rstn && wr_ok) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head word is always presented; rd_en just pops it.
  assign rdata = mem_q[rd_ptr_q];
`else
  logic [DATA_W-1:0] rdata_q;

  // Registered read: capture the head on an accepted pop, hold otherwise.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rdata_q <= '0;
    end else if (rd_ok) begin
      rdata_q <= mem_q[rd_ptr_q];
    end
  end

  assign rdata = rdata_q;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: directed test-plan sequences followed by random
// traffic, every cycle compared against a queue-based reference model.
module tb_sync_fifo_param;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int AF_LV  = 3;
  localparam int AE_LV  = 1;

  logic              clk;
  logic              rstn;
  logic              wr_en;
  logic              rd_en;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [2:0]        count;
  logic              overflow;
  logic              underflow;

  int n_checks;
  int n_fail;

  // Reference model state.
  logic [DATA_W-1:0] model_q[$];
  logic [DATA_W-1:0] exp_rdata;
  logic              exp_ovf;
  logic              exp_udf;

  sync_fifo_param #(
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH),
    .AF_LEVEL(AF_LV),
    .AE_LEVEL(AE_LV)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .wr_en       (wr_en),
    .rd_en       (rd_en),
    .wdata       (wdata),
    .rdata       (rdata),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Apply the FIFO rules to the model for the edge just taken.
  task automatic model_edge();
    bit rd_ok;
    bit wr_ok;
    if (!rstn) begin
      model_q.delete();
      exp_rdata = '0;
      exp_ovf   = 1'b0;
      exp_udf   = 1'b0;
    end else begin
      rd_ok = rd_en && (model_q.size() > 0);
      wr_ok = wr_en && ((model_q.size() < DEPTH) || rd_en);
      if (rd_ok) exp_rdata = model_q.pop_front();
      if (wr_ok) model_q.push_back(wdata);
      exp_ovf = wr_en && !wr_ok;
      exp_udf = rd_en && !rd_ok;
    end
  endtask

  task automatic compare_all();
    int n;
    n = model_q.size();
    check_eq("count",        32'(count),        32'(n));
    check_eq("empty",        32'(empty),        32'(n == 0));
    check_eq("full",         32'(full),         32'(n == DEPTH));
    check_eq("almost_full",  32'(almost_full),  32'(n >= AF_LV));
    check_eq("almost_empty", 32'(almost_empty), 32'(n <= AE_LV));
    check_eq("overflow",     32'(overflow),     32'(exp_ovf));
    check_eq("underflow",    32'(underflow),    32'(exp_udf));
`ifdef SYNC_FIFO_FWFT_EN
    if (n > 0) check_eq("rdata_fwft", 32'(rdata), 32'(model_q[0]));
`else
    check_eq("rdata", 32'(rdata), 32'(exp_rdata));
`endif
  endtask

  // One clock: inputs already stable, update model at the edge, sample 1ns later.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
    $display("t=%0t rstn=%b wr=%b rd=%b wdata=%h | count=%0d rdata=%h ovf=%b udf=%b",
             $time, rstn, wr_en, rd_en, wdata, count, rdata, overflow, underflow);
  endtask

  task automatic op(input logic w, input logic r, input logic [DATA_W-1:0] d);
    wr_en = w;
    rd_en = r;
    wdata = d;
    cycle();
  endtask

  task automatic idle();
    op(1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    logic [DATA_W-1:0] fill_vals [5];
    logic [DATA_W-1:0] d;
    n_checks  = 0;
    n_fail    = 0;
    exp_rdata = '0;
    exp_ovf   = 1'b0;
    exp_udf   = 1'b0;
    fill_vals = '{8'hA5, 8'h5A, 8'hFF, 8'h00, 8'h11};

    // Reset held two cycles while a write is requested.
    rstn = 1'b0;
    op(1'b1, 1'b0, 8'hEE);
    op(1'b1, 1'b0, 8'hEE);
    rstn = 1'b1;
    idle();

    // Fill past capacity, then drain past empty.
    for (int i = 0; i < 5; i++) op(1'b1, 1'b0, fill_vals[i]);
    idle();
    for (int i = 0; i < 5; i++) op(1'b0, 1'b1, 8'h00);
    idle();

    // Simultaneous access while full, then drain.
    for (int i = 0; i < 4; i++) op(1'b1, 1'b0, 8'h40 + 8'(i));
    op(1'b1, 1'b1, 8'h77);
    for (int i = 0; i < 4; i++) op(1'b0, 1'b1, 8'h00);
    check_eq("last_is_77", 32'(rdata), 32'h77);

    // Simultaneous access while empty.
    op(1'b1, 1'b1, 8'h33);
    op(1'b0, 1'b1, 8'h00);
    idle();

    // Interleaved pairs crossing the pointer wrap.
    for (int i = 0; i < 10; i++) begin
      d = 8'($urandom);
      op(1'b1, 1'b0, d);
      op(1'b0, 1'b1, 8'h00);
    end

    // Reset mid-operation with three entries held.
    for (int i = 0; i < 3; i++) op(1'b1, 1'b0, 8'h90 + 8'(i));
    rstn = 1'b0;
    op(1'b0, 1'b0, 8'h00);
    rstn = 1'b1;
    op(1'b1, 1'b0, 8'h5C);
    op(1'b0, 1'b1, 8'h00);
    idle();
    check_eq("after_reset_5C", 32'(rdata), 32'h5C);

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      rstn = ($urandom_range(0, 49) != 0);
      op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
    end
    rstn = 1'b1;
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
